uart_wb_arbiter: RTL and testbench

Round-robin Wishbone arbiter that shares the single UART register-file slave between several requesters: the configuration sequencer, the transfer handler engine, and a debug/RC path. It sits between those masters and the UART core, replacing the static config-done select. It holds a grant for the whole bus cycle (`cyc`). It also guards the bus with a watchdog that terminates a hung cycle with `err`.

---
 rtl/uart_wb_pkg.sv | 16 +
 rtl/uart_wb_arbiter_rr_pick.sv | 31 +++
 rtl/uart_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_uart_wb_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_wb_pkg.sv
// Shared types and default bus geometry for the UART Wishbone arbiter.
// The UART wrappers reuse these defaults so both sides agree on widths.
package uart_wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        ABORT
    } arb_state_t;

    localparam int UART_ADDR_W  = 5;
    localparam int UART_DATA_W  = 32;
    localparam int UART_SEL_W   = 4;
    localparam int UART_TIMEOUT = 64;

endpackage

// File: rtl/uart_wb_arbiter_rr_pick.sv
// Round-robin search: first asserted request at or after ptr,
// wrapping modulo NUM_M.
module rr_pick
    import uart_wb_pkg::*;
#(
    parameter  int NUM_M = 3,
    localparam int IW    = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    int j;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % NUM_M;
            if (req[j]) begin
                idx   = IW'(j);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of the UART register file,
// holding a grant per bus cycle and aborting hung cycles with err.
module uart_wb_arbiter
    import uart_wb_pkg::*;
#(
    parameter  int NUM_M   = 3,
    parameter  int ADDR_W  = UART_ADDR_W,
    parameter  int DATA_W  = UART_DATA_W,
    parameter  int SEL_W   = UART_SEL_W,
    parameter  int TIMEOUT = UART_TIMEOUT,
    localparam int IW      = $clog2(NUM_M),
    localparam int CW      = $clog2(TIMEOUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_M-1:0]        m_cyc,
    input  logic [NUM_M-1:0]        m_stb,
    input  logic [NUM_M-1:0]        m_we,
    input  logic [NUM_M*SEL_W-1:0]  m_sel,
    input  logic [NUM_M*ADDR_W-1:0] m_adr,
    input  logic [NUM_M*DATA_W-1:0] m_dat_w,
    output logic [DATA_W-1:0]       m_dat_r,
    output logic [NUM_M-1:0]        m_ack,
    output logic [NUM_M-1:0]        m_err,
    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [SEL_W-1:0]        s_sel,
    output logic [ADDR_W-1:0]       s_adr,
    output logic [DATA_W-1:0]       s_dat_w,
    input  logic [DATA_W-1:0]       s_dat_r,
    input  logic                    s_ack,
    output logic [IW-1:0]           grant_idx,
    output logic                    busy
);

    arb_state_t    state;
    logic [IW-1:0] rr_ptr;
    logic [CW-1:0] wdog;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic [IW-1:0] next_ptr;

    rr_pick #(
        .NUM_M (NUM_M)
    ) u_pick (
        .req   (m_cyc),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign next_ptr = (grant_idx == IW'(NUM_M - 1)) ?
                      '0 : grant_idx + IW'(1);
    assign busy     = (state != IDLE);

    // Arbitration FSM with the ack watchdog; ack beats a timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            wdog      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    wdog <= '0;
                    if (pick_valid) begin
                        grant_idx <= pick_idx;
                        state     <= OWN;
                    end
                end
                OWN: begin
                    if (!m_cyc[grant_idx]) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                        wdog   <= '0;
                    end else if (s_ack || !m_stb[grant_idx]) begin
                        wdog <= '0;
                    end else if (wdog == CW'(TIMEOUT - 1)) begin
                        state <= ABORT;
                        wdog  <= '0;
                    end else begin
                        wdog <= wdog + CW'(1);
                    end
                end
                ABORT: begin
                    state  <= IDLE;
                    rr_ptr <= next_ptr;
                    wdog   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slave-side mux and master-side ack/err steering by owner.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_sel   = '0;
        s_adr   = '0;
        s_dat_w = '0;
        m_ack   = '0;
        m_err   = '0;
        m_dat_r = '0;
        if (state == OWN) begin
            s_cyc            = m_cyc[grant_idx];
            s_stb            = m_stb[grant_idx];
            s_we             = m_we[grant_idx];
            s_sel            = m_sel[grant_idx*SEL_W +: SEL_W];
            s_adr            = m_adr[grant_idx*ADDR_W +: ADDR_W];
            s_dat_w          = m_dat_w[grant_idx*DATA_W +: DATA_W];
            m_ack[grant_idx] = s_ack;
            m_dat_r          = s_dat_r;
        end
        if (state == ABORT) begin
            m_err[grant_idx] = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Self-checking bench for uart_wb_arbiter with a grant/data scoreboard.
// Inputs change at negedge; outputs are sampled shortly after.
module tb_uart_wb_arbiter;

    localparam int NUM_M   = 3;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 4;
    localparam int TIMEOUT = 8;

    logic                    clk;
    logic                    rst;
    logic [NUM_M-1:0]        m_cyc;
    logic [NUM_M-1:0]        m_stb;
    logic [NUM_M-1:0]        m_we;
    logic [NUM_M*SEL_W-1:0]  m_sel;
    logic [NUM_M*ADDR_W-1:0] m_adr;
    logic [NUM_M*DATA_W-1:0] m_dat_w;
    logic [DATA_W-1:0]       m_dat_r;
    logic [NUM_M-1:0]        m_ack;
    logic [NUM_M-1:0]        m_err;
    logic                    s_cyc;
    logic                    s_stb;
    logic                    s_we;
    logic [SEL_W-1:0]        s_sel;
    logic [ADDR_W-1:0]       s_adr;
    logic [DATA_W-1:0]       s_dat_w;
    logic [DATA_W-1:0]       s_dat_r;
    logic                    s_ack;
    logic [1:0]              grant_idx;
    logic                    busy;

    int checks = 0;
    int passed = 0;
    int sb_g[$];
    logic [DATA_W-1:0] sb_d[$];

    uart_wb_arbiter #(
        .NUM_M   (NUM_M),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .SEL_W   (SEL_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_cyc     (m_cyc),
        .m_stb     (m_stb),
        .m_we      (m_we),
        .m_sel     (m_sel),
        .m_adr     (m_adr),
        .m_dat_w   (m_dat_w),
        .m_dat_r   (m_dat_r),
        .m_ack     (m_ack),
        .m_err     (m_err),
        .s_cyc     (s_cyc),
        .s_stb     (s_stb),
        .s_we      (s_we),
        .s_sel     (s_sel),
        .s_adr     (s_adr),
        .s_dat_w   (s_dat_w),
        .s_dat_r   (s_dat_r),
        .s_ack     (s_ack),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1);
    end

    task automatic set_defaults;
        for (int i = 0; i < NUM_M; i++) begin
            m_adr[i*ADDR_W +: ADDR_W]   = ADDR_W'(i + 1);
            m_dat_w[i*DATA_W +: DATA_W] = DATA_W'(32'hA0 + i);
            m_sel[i*SEL_W +: SEL_W]     = '1;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst     = 1'b1;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = '0;
        s_ack   = 1'b0;
        s_dat_r = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_own(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (s_cyc === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Serve queued grants: ack once, release, optionally re-request.
    task automatic run_grants(input string tag,
                              input logic [NUM_M-1:0] rereq);
        bit ok;
        int g;
        logic [DATA_W-1:0] d;
        while (sb_g.size() > 0) begin
            wait_own(ok);
            checks++;
            if (!ok) begin
                $display("FAIL %s_wait no grant in budget", tag);
                sb_g.delete();
                break;
            end
            passed++;
            g = sb_g.pop_front();
            checks++;
            if (grant_idx !== 2'(g))
                $display("FAIL %s_grant got %0d want %0d",
                         tag, grant_idx, g);
            else passed++;
            checks++;
            if (s_dat_w !== DATA_W'(32'hA0 + g))
                $display("FAIL %s_mux got %h want %h",
                         tag, s_dat_w, 32'hA0 + g);
            else passed++;
            d       = $urandom;
            s_dat_r = d;
            s_ack   = 1'b1;
            #1;
            checks++;
            if (m_ack !== (NUM_M'(1) << g) || m_dat_r !== d)
                $display("FAIL %s_ack got %b/%h want %b/%h",
                         tag, m_ack, m_dat_r, NUM_M'(1) << g, d);
            else passed++;
            @(negedge clk);
            s_ack    = 1'b0;
            m_cyc[g] = 1'b0;
            m_stb[g] = 1'b0;
            @(negedge clk);
            if (rereq[g] && sb_g.size() > $countones(m_cyc)) begin
                m_cyc[g] = 1'b1;
                m_stb[g] = 1'b1;
            end
            #1;
            checks++;
            if (busy !== 1'b0 || s_cyc !== 1'b0)
                $display("FAIL %s_dead busy=%b s_cyc=%b want 0/0",
                         tag, busy, s_cyc);
            else passed++;
        end
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        m_cyc   = '1;
        m_stb   = '1;
        m_we    = '1;
        s_ack   = 1'b1;
        s_dat_r = 32'hDEADBEEF;
        set_defaults();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({s_cyc, s_stb, s_we} !== 3'b000 || s_adr !== '0 ||
            s_sel !== '0 || s_dat_w !== '0)
            $display("FAIL reset_slave got %b%b%b adr=%h want 0",
                     s_cyc, s_stb, s_we, s_adr);
        else passed++;
        checks++;
        if (m_ack !== '0 || m_err !== '0 || m_dat_r !== '0)
            $display("FAIL reset_master ack=%b err=%b dat=%h want 0",
                     m_ack, m_err, m_dat_r);
        else passed++;
        checks++;
        if (grant_idx !== 2'd0 || busy !== 1'b0)
            $display("FAIL reset_grant got %0d/%b want 0/0",
                     grant_idx, busy);
        else passed++;
        do_reset();
    endtask

    task automatic test_single;
        int acks = 0;
        @(negedge clk);
        m_adr[1*ADDR_W +: ADDR_W]   = 5'd3;
        m_dat_w[1*DATA_W +: DATA_W] = 32'hA5;
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        m_we[1]  = 1'b1;
        #1;
        checks++;
        if (s_cyc !== 1'b0)
            $display("FAIL single_early got %b want 0", s_cyc);
        else passed++;
        @(negedge clk);
        #1;
        checks++;
        if (s_cyc !== 1'b1 || s_we !== 1'b1 || s_adr !== 5'd3 ||
            s_dat_w !== 32'hA5 || grant_idx !== 2'd1)
            $display("FAIL single_own got cyc=%b adr=%h dat=%h g=%0d",
                     s_cyc, s_adr, s_dat_w, grant_idx);
        else passed++;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                @(negedge clk);
            end
            s_ack = (c == 2);
            #1;
            if (m_ack[1] === 1'b1) acks++;
            if (m_ack[0] === 1'b1 || m_ack[2] === 1'b1) acks += 10;
        end
        checks++;
        if (acks !== 1)
            $display("FAIL single_acks got %0d want 1", acks);
        else passed++;
        s_ack = 1'b0;
        @(negedge clk);
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        m_we[1]  = 1'b0;
        set_defaults();
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0)
            $display("FAIL single_release busy=%b want 0", busy);
        else passed++;
    endtask

    task automatic test_contention;
        do_reset();
        m_cyc = 3'b111;
        m_stb = 3'b111;
        sb_g.push_back(0);
        sb_g.push_back(1);
        sb_g.push_back(2);
        run_grants("contention", 3'b000);
    endtask

    task automatic test_fairness;
        do_reset();
        m_cyc = 3'b101;
        m_stb = 3'b101;
        sb_g.push_back(0);
        sb_g.push_back(2);
        sb_g.push_back(0);
        sb_g.push_back(2);
        run_grants("fairness", 3'b101);
        checks++;
        if (m_cyc !== 3'b000)
            $display("FAIL fairness_drain got %b want 000", m_cyc);
        else passed++;
    endtask

    task automatic test_burst;
        bit ok;
        int acks = 0;
        int held_bad = 0;
        logic [DATA_W-1:0] v;
        m_cyc[2] = 1'b1;
        m_stb[2] = 1'b1;
        m_we[2]  = 1'b0;
        wait_own(ok);
        checks++;
        if (!ok || grant_idx !== 2'd2)
            $display("FAIL burst_grant ok=%b g=%0d want 1/2",
                     ok, grant_idx);
        else passed++;
        for (int b = 0; b < 4; b++) begin
            v = 32'h11 * (b + 1);
            sb_d.push_back(v);
            s_dat_r = v;
            s_ack   = 1'b1;
            #1;
            if (m_ack === 3'b100) acks++;
            v = sb_d.pop_front();
            checks++;
            if (m_dat_r !== v)
                $display("FAIL burst_data%0d got %h want %h",
                         b, m_dat_r, v);
            else passed++;
            @(negedge clk);
            s_ack = 1'b0;
            #1;
            if (grant_idx !== 2'd2 || busy !== 1'b1 ||
                s_cyc !== 1'b1 || m_ack !== 3'b000)
                held_bad++;
            @(negedge clk);
        end
        checks++;
        if (acks !== 4)
            $display("FAIL burst_acks got %0d want 4", acks);
        else passed++;
        checks++;
        if (held_bad !== 0)
            $display("FAIL burst_hold got %0d bad want 0", held_bad);
        else passed++;
        m_cyc[2] = 1'b0;
        m_stb[2] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout;
        bit ok;
        int bad = 0;
        do_reset();
        m_cyc = 3'b011;
        m_stb = 3'b011;
        m_we  = 3'b011;
        wait_own(ok);
        checks++;
        if (!ok || grant_idx !== 2'd0)
            $display("FAIL timeout_grant ok=%b g=%0d want 1/0",
                     ok, grant_idx);
        else passed++;
        for (int k = 1; k < TIMEOUT; k++) begin
            @(negedge clk);
            #1;
            if (m_err !== 3'b000 || s_cyc !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0)
            $display("FAIL timeout_early got %0d bad want 0", bad);
        else passed++;
        @(negedge clk);
        #1;
        checks++;
        if (m_err !== 3'b001 || s_cyc !== 1'b0 ||
            s_stb !== 1'b0 || m_ack !== 3'b000 || busy !== 1'b1)
            $display("FAIL timeout_err err=%b s_cyc=%b busy=%b",
                     m_err, s_cyc, busy);
        else passed++;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        m_we     = 3'b000;
        @(negedge clk);
        #1;
        checks++;
        if (m_err !== 3'b000 || busy !== 1'b0)
            $display("FAIL timeout_pulse err=%b busy=%b want 0/0",
                     m_err, busy);
        else passed++;
        sb_g.push_back(1);
        run_grants("timeout_next", 3'b000);
    endtask

    task automatic test_ack_at_limit;
        bit ok;
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        wait_own(ok);
        repeat (TIMEOUT - 1) @(negedge clk);
        s_ack = 1'b1;
        #1;
        checks++;
        if (!ok || m_ack !== 3'b010)
            $display("FAIL limit_ack got %b want 010", m_ack);
        else passed++;
        @(negedge clk);
        s_ack = 1'b0;
        #1;
        checks++;
        if (m_err !== 3'b000 || s_cyc !== 1'b1)
            $display("FAIL limit_noerr err=%b s_cyc=%b want 000/1",
                     m_err, s_cyc);
        else passed++;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_async_reset;
        bit ok;
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        wait_own(ok);
        s_dat_r = 32'h55;
        s_ack   = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (!ok || s_cyc !== 1'b0 || s_stb !== 1'b0 ||
            m_ack !== '0 || m_dat_r !== '0 || busy !== 1'b0 ||
            grant_idx !== 2'd0 || s_dat_w !== '0)
            $display("FAIL async_rst cyc=%b ack=%b busy=%b g=%0d",
                     s_cyc, m_ack, busy, grant_idx);
        else passed++;
        s_ack = 1'b0;
        m_cyc = 3'b011;
        m_stb = 3'b011;
        @(negedge clk);
        rst = 1'b0;
        sb_g.push_back(0);
        sb_g.push_back(1);
        run_grants("post_rst", 3'b000);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_burst();
        test_timeout();
        test_ack_at_limit();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
